// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic operand feeder.
// The optional stall input of systolic_skew_feeder is enabled by SYSTOLIC_FEEDER_STALL_EN.
package systolic_pkg;

    localparam int DATA_SIZE     = 8;
    localparam int SYSTOLIC_SIZE = 2;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH,
        DONE
    } feeder_state_t;

    typedef struct packed {
        logic [DATA_SIZE-1:0] data;
        logic                 valid;
        logic                 first;
    } lane_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register of lane records; one instance per lane gives the triangular skew.
// A hold input freezes every stage so a stalled feeder keeps its lanes aligned.
module skew_delay_line
    import systolic_pkg::*;
#(
    parameter int  N      = 1,
    parameter type elem_t = lane_t
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  hold_i,
    input  elem_t lane_i,
    output elem_t lane_o
);

    elem_t stage_q [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                stage_q[k] <= '0;
            end
        end else if (!hold_i) begin
            stage_q[0] <= lane_i;
            for (int k = 1; k < N; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign lane_o = stage_q[N-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds one skewed matrix-multiply pass of A row-vectors into the first systolic column.
// Defining SYSTOLIC_FEEDER_STALL_EN adds a stall input that freezes the whole feeder.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int data_size     = DATA_SIZE,
    parameter int systolic_size = SYSTOLIC_SIZE,
    parameter int klen_width    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef SYSTOLIC_FEEDER_STALL_EN
    input  logic                  stall,
`endif
    input  logic                  start,
    input  logic [klen_width-1:0] k_len,
    input  logic [data_size-1:0]  vec_in [0:systolic_size-1],
    input  logic                  vec_valid,
    output logic                  vec_ready,
    output logic [data_size-1:0]  out_a [0:systolic_size-1],
    output logic [systolic_size-1:0] out_valid,
    output logic [systolic_size-1:0] cal_ele_cho_out,
    output logic                  busy,
    output logic                  done
);

    localparam int FW = (systolic_size > 1) ? $clog2(systolic_size) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(systolic_size - 1);

    typedef struct packed {
        logic [data_size-1:0] data;
        logic                 valid;
        logic                 first;
    } feedLane_t;

    feeder_state_t         state_q;
    logic [klen_width-1:0] kLen_q;
    logic [klen_width-1:0] count_q;
    logic [klen_width-1:0] count_d;
    logic [FW-1:0]         flushCnt_q;
    logic                  zeroPass_q;
    logic                  vecReady_q;
    logic                  busy_q;
    logic                  done_q;

    logic stallW;
    logic accept;
    logic first;
    logic lastAccept;

`ifdef SYSTOLIC_FEEDER_STALL_EN
    assign stallW    = stall;
    assign vec_ready = vecReady_q & ~stall;
`else
    assign stallW    = 1'b0;
    assign vec_ready = vecReady_q;
`endif

    assign accept     = vec_valid & vec_ready;
    assign first      = accept & (count_q == '0);
    assign count_d    = count_q + klen_width'(1);
    assign lastAccept = accept & (count_d == kLen_q);

    // A zero-length pass spends an extra cycle in DONE so done lands two cycles after start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            kLen_q     <= '0;
            count_q    <= '0;
            flushCnt_q <= '0;
            zeroPass_q <= 1'b0;
            vecReady_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (!stallW) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        if (k_len != '0) begin
                            kLen_q     <= k_len;
                            vecReady_q <= 1'b1;
                            state_q    <= FEED;
                        end else begin
                            zeroPass_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                FEED: begin
                    if (accept) begin
                        count_q <= count_d;
                        if (lastAccept) begin
                            vecReady_q <= 1'b0;
                            flushCnt_q <= '0;
                            state_q    <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flushCnt_q == FLUSH_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        flushCnt_q <= flushCnt_q + FW'(1);
                    end
                end
                DONE: begin
                    if (zeroPass_q) begin
                        zeroPass_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    // Lane i gets i+1 stages; idle cycles push zeroed bubbles so the lanes stay aligned.
    for (genvar i = 0; i < systolic_size; i++) begin : gLane
        feedLane_t laneIn;
        feedLane_t laneOut;

        assign laneIn.data  = accept ? vec_in[i] : '0;
        assign laneIn.valid = accept;
        assign laneIn.first = first;

        skew_delay_line #(
            .N      (i + 1),
            .elem_t (feedLane_t)
        ) uDelay (
            .clk    (clk),
            .reset  (reset),
            .hold_i (stallW),
            .lane_i (laneIn),
            .lane_o (laneOut)
        );

        assign out_a[i]           = laneOut.data;
        assign out_valid[i]       = laneOut.valid;
        assign cal_ele_cho_out[i] = laneOut.first;
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized scoreboard bench for systolic_skew_feeder (default build, four lanes).
module tb_systolic_skew_feeder;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int KW    = 8;

    typedef struct {
        int           cyc;
        logic [DW-1:0] data;
        logic         first;
    } laneEv_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [KW-1:0] kLen;
    logic [DW-1:0] vecIn [0:LANES-1];
    logic          vecValid;
    logic          vecReady;
    logic [DW-1:0] outA [0:LANES-1];
    logic [LANES-1:0] outValid;
    logic [LANES-1:0] calOut;
    logic          busy;
    logic          done;

    int  cyc;
    int  checks;
    int  errors;
    bit  monEn;

    laneEv_t laneQ [LANES][$];
    int      doneQ [$];
    bit      readyMap [int];
    bit      busyMap [int];

    systolic_skew_feeder #(
        .data_size     (DW),
        .systolic_size (LANES),
        .klen_width    (KW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .k_len           (kLen),
        .vec_in          (vecIn),
        .vec_valid       (vecValid),
        .vec_ready       (vecReady),
        .out_a           (outA),
        .out_valid       (outValid),
        .cal_ele_cho_out (calOut),
        .busy            (busy),
        .done            (done)
    );

    // Free-running clock and a cycle index shared by driver and monitor.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle, each lane must show exactly the scheduled element or a zeroed bubble.
    always @(negedge clk) begin
        if (monEn) begin
            for (int i = 0; i < LANES; i++) begin
                laneEv_t e;
                logic          expV;
                logic [DW-1:0] expD;
                logic          expF;
                expV = 1'b0;
                expD = '0;
                expF = 1'b0;
                if (laneQ[i].size() > 0 && laneQ[i][0].cyc == cyc) begin
                    e    = laneQ[i].pop_front();
                    expV = 1'b1;
                    expD = e.data;
                    expF = e.first;
                end
                checkOutput($sformatf("lane%0d_valid", i), 32'(outValid[i]), 32'(expV));
                checkOutput($sformatf("lane%0d_data", i), 32'(outA[i]), 32'(expD));
                checkOutput($sformatf("lane%0d_first", i), 32'(calOut[i]), 32'(expF));
            end
            begin
                logic expDone;
                expDone = 1'b0;
                if (doneQ.size() > 0 && doneQ[0] == cyc) begin
                    void'(doneQ.pop_front());
                    expDone = 1'b1;
                end
                checkOutput("done", 32'(done), 32'(expDone));
            end
            checkOutput("vec_ready", 32'(vecReady), 32'(readyMap.exists(cyc)));
            checkOutput("busy", 32'(busy), 32'(busyMap.exists(cyc)));
        end
    end

    task automatic randomizeVec();
        for (int i = 0; i < LANES; i++) vecIn[i] = DW'($urandom);
    endtask

    // gapMode: 0 = valid every cycle, 1 = two idle cycles between vectors, 2 = random gaps.
    task automatic applyStimulus(input int k, input int gapMode, input bit directed);
        int s;
        int n;
        int gapCnt;
        int doneCyc;
        nextCycle();
        s        = cyc;
        start    = 1'b1;
        kLen     = KW'(k);
        vecValid = 1'b0;
        randomizeVec();
        doneCyc  = s + 2;
        if (k == 0) begin
            doneQ.push_back(doneCyc);
            busyMap[s + 1] = 1'b1;
            busyMap[s + 2] = 1'b1;
        end else begin
            n      = 0;
            gapCnt = 0;
            while (n < k) begin
                nextCycle();
                start = ($urandom_range(0, 3) == 0);
                kLen  = KW'($urandom);
                readyMap[cyc] = 1'b1;
                busyMap[cyc]  = 1'b1;
                randomizeVec();
                if (gapMode == 0) vecValid = 1'b1;
                else if (gapMode == 1) vecValid = (gapCnt == 0);
                else vecValid = ($urandom_range(0, 2) != 0);
                if (gapCnt > 0) gapCnt--;
                if (vecValid) begin
                    for (int i = 0; i < LANES; i++) begin
                        laneEv_t e;
                        if (directed) vecIn[i] = DW'(n * LANES + i + 1);
                        e.cyc   = cyc + 1 + i;
                        e.data  = vecIn[i];
                        e.first = (n == 0);
                        laneQ[i].push_back(e);
                    end
                    n++;
                    gapCnt = 2;
                    if (n == k) begin
                        doneCyc = cyc + LANES + 1;
                        doneQ.push_back(doneCyc);
                        for (int c = cyc + 1; c <= doneCyc; c++) busyMap[c] = 1'b1;
                    end
                end
            end
        end
        while (cyc < doneCyc) begin
            nextCycle();
            start    = ($urandom_range(0, 1) == 0);
            kLen     = KW'($urandom_range(0, 5));
            vecValid = ($urandom_range(0, 1) == 0);
            randomizeVec();
        end
        nextCycle();
        start    = 1'b0;
        vecValid = 1'b0;
    endtask

    // Abort a k_len=3 pass after its first accept; nothing after the reset edge may appear.
    task automatic resetMidFeed();
        int r;
        nextCycle();
        start    = 1'b1;
        kLen     = 8'd3;
        vecValid = 1'b0;
        nextCycle();
        start    = 1'b1;
        kLen     = 8'd5;
        readyMap[cyc] = 1'b1;
        busyMap[cyc]  = 1'b1;
        randomizeVec();
        vecValid = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            laneEv_t e;
            e.cyc   = cyc + 1 + i;
            e.data  = vecIn[i];
            e.first = 1'b1;
            laneQ[i].push_back(e);
        end
        nextCycle();
        start    = 1'b0;
        vecValid = 1'b0;
        readyMap[cyc] = 1'b1;
        busyMap[cyc]  = 1'b1;
        reset = 1'b1;
        r     = cyc;
        for (int i = 0; i < LANES; i++) begin
            while (laneQ[i].size() > 0 && laneQ[i][laneQ[i].size() - 1].cyc > r) begin
                void'(laneQ[i].pop_back());
            end
        end
        nextCycle();
        reset = 1'b0;
        repeat (3) nextCycle();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        monEn    = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        kLen     = '0;
        vecValid = 1'b0;
        for (int i = 0; i < LANES; i++) vecIn[i] = '0;

        repeat (3) nextCycle();
        reset = 1'b0;
        monEn = 1'b1;
        repeat (10) nextCycle();

        applyStimulus(3, 0, 1'b1);
        applyStimulus(2, 1, 1'b0);
        applyStimulus(0, 0, 1'b0);
        resetMidFeed();
        applyStimulus(1, 0, 1'b0);
        for (int p = 0; p < 10; p++) begin
            applyStimulus($urandom_range(0, 6), 2, 1'b0);
            repeat ($urandom_range(0, 2)) nextCycle();
        end
        applyStimulus(5, 1, 1'b1);

        repeat (4) nextCycle();
        for (int i = 0; i < LANES; i++) begin
            checkOutput($sformatf("lane%0d_pending", i), 32'(laneQ[i].size()), 32'd0);
        end
        checkOutput("done_pending", 32'(doneQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
